// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : i2c_arb_pkg
// Description : Shared widths, defaults and FSM encoding for the I2C bus
//               arbiter that multiplexes one I2C engine between requesters.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    // Engine command / response field widths
    localparam int CMD_W  = 32;
    localparam int NM_W   = 5;
    localparam int RD_W   = 24;
    localparam int ERRT_W = 8;

    // Width of the watchdog and gap counters
    localparam int CNT_W  = 16;

    // Default timing parameters
    localparam int DEF_TIMEOUT_CYC = 50000;
    localparam int DEF_GAP_CYC     = 4;

    // Arbiter transaction states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_e;

endpackage : i2c_arb_pkg
`default_nettype wire

// File: rtl/i2c_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : i2c_rr_pick
// Description : Combinational round-robin selector. Returns the first set
//               request bit found searching upward from last+1 with
//               wrap-around, as an index and as a one-hot vector.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_sel,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic               o_any
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit after
    // i_last is the one that survives.
    always_comb begin
        w_idx    = 0;
        o_sel    = '0;
        o_onehot = '0;
        o_any    = |i_req;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_idx = (int'(i_last) + off) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_sel = IDX_W'(w_idx);
            end
        end
        if (o_any) begin
            o_onehot[o_sel] = 1'b1;
        end
    end

endmodule : i2c_rr_pick
`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_arbiter
// Description : Shares one I2C engine between NUM_REQ requesters. Round-robin
//               grant, command capture, engine handshake, per-transaction
//               watchdog and an engine-release gap between transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC
) (
    input  logic                    clk_I2C,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_wr,
    input  logic [CMD_W*NUM_REQ-1:0] req_wdata,
    input  logic [CMD_W*NUM_REQ-1:0] req_rdata,
    input  logic [NM_W*NUM_REQ-1:0] req_nm,
    input  logic [ERRT_W-1:0]       err_limit,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done_pulse,
    output logic [NUM_REQ-1:0]      err_pulse,
    output logic [RD_W-1:0]         rd_data,
    output logic                    busy,
    output logic                    bus_en,
    output logic                    bus_wr,
    output logic [CMD_W-1:0]        bus_wdata,
    output logic [CMD_W-1:0]        bus_rdata,
    output logic [NM_W-1:0]         bus_nm,
    input  logic                    bus_done,
    input  logic [ERRT_W-1:0]       bus_error_time,
    input  logic [RD_W-1:0]         bus_read_data
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e          state_q,     state_d;
    logic [NUM_REQ-1:0]  gnt_q,       gnt_d;
    logic [NUM_REQ-1:0]  done_q,      done_d;
    logic [NUM_REQ-1:0]  err_q,       err_d;
    logic [RD_W-1:0]     rd_data_q,   rd_data_d;
    logic                busy_q,      busy_d;
    logic                bus_en_q,    bus_en_d;
    logic                bus_wr_q,    bus_wr_d;
    logic [CMD_W-1:0]    bus_wdata_q, bus_wdata_d;
    logic [CMD_W-1:0]    bus_rdata_q, bus_rdata_d;
    logic [NM_W-1:0]     bus_nm_q,    bus_nm_d;
    logic [IDX_W-1:0]    sel_q,       sel_d;
    logic [IDX_W-1:0]    last_q,      last_d;
    logic [CNT_W-1:0]    tmo_q,       tmo_d;
    logic [CNT_W-1:0]    gap_q,       gap_d;

    logic [IDX_W-1:0]    w_pick_sel;
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic                w_pick_any;
    logic                w_abort;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_last   (last_q),
        .o_sel    (w_pick_sel),
        .o_onehot (w_pick_onehot),
        .o_any    (w_pick_any)
    );

    // Engine error limit or watchdog expiry; bus_done outranks both.
    assign w_abort = (bus_error_time > err_limit) ||
                     (tmo_q == CNT_W'(TIMEOUT_CYC - 1));

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = '0;
        rd_data_d   = rd_data_q;
        busy_d      = busy_q;
        bus_en_d    = bus_en_q;
        bus_wr_d    = bus_wr_q;
        bus_wdata_d = bus_wdata_q;
        bus_rdata_d = bus_rdata_q;
        bus_nm_d    = bus_nm_q;
        sel_d       = sel_q;
        last_d      = last_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    gnt_d       = w_pick_onehot;
                    busy_d      = 1'b1;
                    sel_d       = w_pick_sel;
                    // Command is frozen here for the whole transaction.
                    bus_wr_d    = req_wr[w_pick_sel];
                    bus_wdata_d = req_wdata[CMD_W*w_pick_sel +: CMD_W];
                    bus_rdata_d = req_rdata[CMD_W*w_pick_sel +: CMD_W];
                    bus_nm_d    = req_nm[NM_W*w_pick_sel +: NM_W];
                    state_d     = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                bus_en_d = 1'b1;
                tmo_d    = '0;
                state_d  = ST_WAIT;
            end

            ST_WAIT: begin
                tmo_d = tmo_q + CNT_W'(1);
                if (bus_done || w_abort) begin
                    bus_en_d = 1'b0;
                    gnt_d    = '0;
                    last_d   = sel_q;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                    if (bus_done) begin
                        done_d[sel_q] = 1'b1;
                        rd_data_d     = bus_read_data;
                    end else begin
                        err_d[sel_q]  = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == CNT_W'(GAP_CYC - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset also drops bus_en to stop the engine.
    always_ff @(posedge clk_I2C) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            bus_en_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_wdata_q <= '0;
            bus_rdata_q <= '0;
            bus_nm_q    <= '0;
            sel_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            tmo_q       <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
            bus_en_q    <= bus_en_d;
            bus_wr_q    <= bus_wr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_rdata_q <= bus_rdata_d;
            bus_nm_q    <= bus_nm_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
        end
    end

    assign gnt        = gnt_q;
    assign done_pulse = done_q;
    assign err_pulse  = err_q;
    assign rd_data    = rd_data_q;
    assign busy       = busy_q;
    assign bus_en     = bus_en_q;
    assign bus_wr     = bus_wr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_rdata  = bus_rdata_q;
    assign bus_nm     = bus_nm_q;

endmodule : i2c_bus_arbiter
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_bus_arbiter
// Description : Directed self-checking bench for i2c_bus_arbiter with two
//               requesters, a 20-cycle watchdog and a 4-cycle release gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TMO     = 20;
    localparam int GAP     = 4;

    logic                 clk_I2C = 1'b0;
    logic                 reset_n;
    logic [1:0]           req;
    logic [1:0]           req_wr;
    logic [63:0]          req_wdata;
    logic [63:0]          req_rdata;
    logic [9:0]           req_nm;
    logic [7:0]           err_limit;
    logic [1:0]           gnt;
    logic [1:0]           done_pulse;
    logic [1:0]           err_pulse;
    logic [23:0]          rd_data;
    logic                 busy;
    logic                 bus_en;
    logic                 bus_wr;
    logic [31:0]          bus_wdata;
    logic [31:0]          bus_rdata;
    logic [4:0]           bus_nm;
    logic                 bus_done;
    logic [7:0]           bus_error_time;
    logic [23:0]          bus_read_data;

    int n_assert = 0;
    int n_fail   = 0;

    i2c_bus_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TMO),
        .GAP_CYC     (GAP)
    ) dut (
        .clk_I2C        (clk_I2C),
        .reset_n        (reset_n),
        .req            (req),
        .req_wr         (req_wr),
        .req_wdata      (req_wdata),
        .req_rdata      (req_rdata),
        .req_nm         (req_nm),
        .err_limit      (err_limit),
        .gnt            (gnt),
        .done_pulse     (done_pulse),
        .err_pulse      (err_pulse),
        .rd_data        (rd_data),
        .busy           (busy),
        .bus_en         (bus_en),
        .bus_wr         (bus_wr),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .bus_nm         (bus_nm),
        .bus_done       (bus_done),
        .bus_error_time (bus_error_time),
        .bus_read_data  (bus_read_data)
    );

    always #5 clk_I2C = ~clk_I2C;

    // Advance n rising edges, landing 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_I2C);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n        = 1'b0;
        req            = 2'b00;
        req_wr         = 2'b00;
        req_wdata      = '0;
        req_rdata      = '0;
        req_nm         = '0;
        err_limit      = 8'd3;
        bus_done       = 1'b0;
        bus_error_time = 8'd0;
        bus_read_data  = 24'd0;

        // ---------------- reset state ----------------
        step(2);
        chk("rst_gnt",   64'(gnt), 64'h0);
        chk("rst_en",    64'({busy, bus_en}), 64'h0);
        chk("rst_pulse", 64'({done_pulse, err_pulse}), 64'h0);
        chk("rst_bus",   64'({bus_wr, bus_wdata, bus_nm}), 64'h0);
        chk("rst_rd",    64'(rd_data), 64'h0);
        reset_n = 1'b1;
        step(1);
        chk("idle_noreq", 64'({gnt, busy, bus_en}), 64'h0);

        // ---------------- single request ----------------
        req_wdata[31:0] = 32'h00D06B40;
        req_nm[4:0]     = 5'd3;
        req             = 2'b01;
        step(1);                                // +1
        chk("t1_gnt",   64'(gnt), 64'h1);
        chk("t1_busy",  64'(busy), 64'h1);
        chk("t1_en_lo", 64'(bus_en), 64'h0);
        chk("t1_wdata", 64'(bus_wdata), 64'h00D06B40);
        chk("t1_nm",    64'(bus_nm), 64'h3);
        req_wdata[31:0] = 32'hDEADBEEF;         // must be ignored
        req_nm[4:0]     = 5'd17;
        step(1);                                // +2
        chk("t1_en_hi", 64'(bus_en), 64'h1);
        step(7);                                // +9
        chk("t1_latch", 64'({bus_wdata, 27'd0, bus_nm}), {32'h00D06B40, 32'h3});
        chk("t1_nodone", 64'(done_pulse), 64'h0);
        step(1);                                // +10
        bus_done = 1'b1;
        step(1);                                // +11
        chk("t1_done",  64'(done_pulse), 64'h1);
        chk("t1_endtx", 64'({gnt, bus_en, busy}), 64'h1);
        chk("t1_noerr", 64'(err_pulse), 64'h0);
        bus_done = 1'b0;
        req      = 2'b00;
        step(1);                                // +12
        chk("t1_pulse1", 64'(done_pulse), 64'h0);
        step(2);                                // +14
        chk("t1_gapbusy", 64'(busy), 64'h1);
        step(1);                                // +15
        chk("t1_busyfall", 64'(busy), 64'h0);

        // ---------------- contention ----------------
        reset_n = 1'b0;
        step(1);
        reset_n   = 1'b1;
        req_wdata = {32'hBBBB0001, 32'hAAAA0000};
        req       = 2'b11;
        for (int t = 0; t < 4; t++) begin
            step(1);
            chk("c_gnt", 64'(gnt), (t % 2 == 0) ? 64'h1 : 64'h2);
            chk("c_wdata", 64'(bus_wdata), (t % 2 == 0) ? 64'hAAAA0000 : 64'hBBBB0001);
            step(1);
            chk("c_en", 64'(bus_en), 64'h1);
            bus_done = 1'b1;
            step(1);
            chk("c_done", 64'(done_pulse), (t % 2 == 0) ? 64'h1 : 64'h2);
            bus_done = 1'b0;
            for (int g = 0; g < GAP; g++) begin
                step(1);
                chk("c_gap", 64'({gnt, bus_en}), 64'h0);
            end
            chk("c_gapend_busy", 64'(busy), 64'h0);
        end
        req = 2'b00;

        // ---------------- read return (requester 1) ----------------
        req_wr           = 2'b10;
        req_rdata[63:32] = 32'h00D10000;
        req              = 2'b10;
        step(1);
        chk("r_gnt", 64'(gnt), 64'h2);
        chk("r_cmd", 64'({bus_wr, bus_rdata}), {31'd0, 1'b1, 32'h00D10000});
        req = 2'b00;
        step(1);
        chk("r_en", 64'(bus_en), 64'h1);
        bus_done      = 1'b1;
        bus_read_data = 24'h1234AB;
        step(1);
        chk("r_done", 64'(done_pulse), 64'h2);
        chk("r_data", 64'(rd_data), 64'h1234AB);
        bus_done      = 1'b0;
        bus_read_data = 24'h000000;
        step(GAP);

        // ---------------- engine error (requester 0) ----------------
        req_wr = 2'b00;
        req    = 2'b01;
        step(1);
        chk("e_gnt", 64'(gnt), 64'h1);
        req = 2'b00;
        step(1);
        chk("e_en", 64'(bus_en), 64'h1);
        bus_error_time = 8'd3;                  // equal to limit: no abort
        step(2);
        chk("e_noabort", 64'({bus_en, err_pulse}), 64'h4);
        bus_error_time = 8'd4;
        step(1);
        chk("e_err",    64'(err_pulse), 64'h1);
        chk("e_nodone", 64'(done_pulse), 64'h0);
        chk("e_en_lo",  64'({gnt, bus_en}), 64'h0);
        chk("e_rdhold", 64'(rd_data), 64'h1234AB);
        bus_error_time = 8'd0;
        req            = 2'b11;
        step(GAP);

        // ---------------- pointer advanced, then timeout ----------------
        step(1);
        chk("p_gnt", 64'(gnt), 64'h2);
        req = 2'b00;
        step(1);                                // bus_en rises
        chk("to_en", 64'(bus_en), 64'h1);
        step(TMO - 1);
        chk("to_early", 64'({bus_en, err_pulse}), 64'h4);
        step(1);
        chk("to_err",    64'(err_pulse), 64'h2);
        chk("to_nodone", 64'({done_pulse, bus_en}), 64'h0);
        step(GAP);

        // ---------------- done and error together ----------------
        req = 2'b01;
        step(1);
        chk("de_gnt", 64'(gnt), 64'h1);
        req = 2'b00;
        step(1);
        bus_done       = 1'b1;
        bus_error_time = 8'd9;
        bus_read_data  = 24'hABCDEF;
        step(1);
        chk("de_pulses", 64'({done_pulse, err_pulse}), 64'h4);
        chk("de_rd",     64'(rd_data), 64'hABCDEF);
        bus_done       = 1'b0;
        bus_error_time = 8'd0;
        step(GAP);

        // ---------------- reset mid-WAIT ----------------
        req = 2'b11;                            // last = 0 so requester 1 wins
        step(1);
        chk("rw_gnt", 64'(gnt), 64'h2);
        step(3);
        chk("rw_inwait", 64'(bus_en), 64'h1);
        reset_n = 1'b0;
        step(1);
        chk("rw_rst_ctl",  64'({gnt, busy, bus_en, done_pulse, err_pulse}), 64'h0);
        chk("rw_rst_data", 64'({bus_wdata, rd_data}), 64'h0);
        reset_n = 1'b1;
        step(1);
        chk("rw_regnt", 64'(gnt), 64'h1);
        req = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_i2c_bus_arbiter
`default_nettype wire

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C_Bus engine (one SCL/SDA pair) between NUM_REQ transaction requesters, e.g. the accelerometer sequencer and the pressure-sensor PROM/ADC sequencer.
- Runs a round-robin grant and captures the granted requester's command.
- Drives the engine's en/wr/wdata/rdata/NM handshake, then returns done, error and read data to the granted requester only.
- Adds a per-transaction watchdog and an engine-release gap between transactions.

Parameters:
- NUM_REQ, 2: number of requesters (legal 2..4).
- TIMEOUT_CYC, 50000: clk_I2C cycles allowed from engine enable to bus_done before abort (16-bit).
- GAP_CYC, 4: cycles bus_en is held low between consecutive transactions (minimum 1).

Ports:
- clk_I2C  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester transaction request (level).
- req_wr  in  NUM_REQ  per-requester wr flag (0 = write phase, 1 = read phase).
- req_wdata  in  32*NUM_REQ  per-requester write word, slice i = [32i+31:32i].
- req_rdata  in  32*NUM_REQ  per-requester read-address word.
- req_nm  in  5*NUM_REQ  per-requester byte count.
- err_limit  in  8  abort when bus_error_time > err_limit.
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- done_pulse  out  NUM_REQ  1-cycle success strobe to the granted requester.
- err_pulse  out  NUM_REQ  1-cycle abort strobe (engine error limit or timeout).
- rd_data  out  24  ReadData captured at completion; valid with done_pulse and held until the next completion.
- busy  out  1  high from grant until the end of the gap.
- bus_en  out  1  engine enable.
- bus_wr  out  1  to engine.
- bus_wdata  out  32  to engine.
- bus_rdata  out  32  to engine.
- bus_nm  out  5  to engine.
- bus_done  in  1  engine completion.
- bus_error_time  in  8  engine retry count.
- bus_read_data  in  24  engine read result.

Behaviour:
- Reset (synchronous, reset_n=0 at a clk_I2C edge): state=IDLE. All outputs are 0, including gnt, bus_en, bus_* fields, rd_data, busy and both pulse vectors. Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- A reset mid-transaction drops bus_en on that edge; the engine is expected to reset with it.
- IDLE: if any req bit is set, select the first set bit searching from last+1 with wrap-around (index NUM_REQ-1 wraps to 0).
  - Same edge: gnt=onehot(sel), busy=1.
  - Latch req_wr/req_wdata/req_rdata/req_nm of sel into the bus_* registers.
  - Go to LAUNCH.
  - No request: stay in IDLE with all outputs idle.
- LAUNCH (1 cycle): bus_en=1, timeout counter cleared, go to WAIT.
- WAIT: bus_en stays 1 and the counter increments each cycle.
  - bus_done=1: bus_en=0, rd_data<=bus_read_data, done_pulse[sel]=1 for one cycle, last<=sel, go to GAP.
  - else if bus_error_time > err_limit: bus_en=0, err_pulse[sel]=1, last<=sel, go to GAP.
  - else if counter == TIMEOUT_CYC-1: same as the error case (abort).
  - Priority within WAIT: done > error > timeout.
- GAP: gnt=0, bus_en=0, count GAP_CYC cycles. On the last cycle busy=0 and go to IDLE; arbitration resumes on the following edge.
- Command latching: bus_* fields are frozen from grant to the end of the transaction. Changes on the requester side are ignored.
- req deasserted during LAUNCH/WAIT: the transaction still completes and done/err pulses still fire.
- Latency: req rise in IDLE -> gnt on the next edge -> bus_en one edge after that. bus_done -> done_pulse on the next edge.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- Requester contract: each requester drops or re-evaluates req after its done/err pulse. A req still high after GAP is treated as a new transaction.
- Only one gnt and one pulse bit are ever set at a time.

Decomposition:
- Package i2c_arb_pkg contains:
  - state encoding (IDLE, LAUNCH, WAIT, GAP);
  - widths CMD_W=32, NM_W=5, RD_W=24, ERRT_W=8;
  - default TIMEOUT_CYC and GAP_CYC.
- Sub-module i2c_rr_pick: combinational round-robin selector. Inputs are the req vector and last; outputs are sel index, onehot and any.

Test Plan:
- Single request: req=2'b01, wdata=32'h00D06B40, nm=3. Expect gnt=01 at +1, bus_en at +2 and bus_wdata=32'h00D06B40. Engine done at +10 → done_pulse=01 at +11, bus_en=0 and gnt=0; busy falls after 4 gap cycles.
- Contention: req=2'b11 held for 4 transactions. Expect grant order 0,1,0,1, each separated by exactly GAP_CYC idle cycles with bus_en low.
- Read return: requester 1, wr=1, rdata=32'h00D10000, bus_read_data=24'h1234AB at done. Expect rd_data=24'h1234AB together with done_pulse=10; rd_data unchanged through the next requester's error abort.
- Engine error: err_limit=3, bus_error_time raised to 4 mid-WAIT. Expect err_pulse for the granted requester on the next edge, bus_en=0, no done_pulse, and the pointer advanced.
- Timeout: TIMEOUT_CYC=20, bus_done never asserted. Expect err_pulse exactly 20 cycles after bus_en rises; done and error arriving together in one cycle gives done_pulse only.
- Reset mid-WAIT: reset_n=0 for one edge. Expect all outputs 0 on that edge; after release, req=11 grants requester 0 first.
